// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the MEM pipeline stage
package mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic BR_BEQ = 1'b0;
  localparam logic BR_BNE = 1'b1;

  // beq resolves on zero, bne on non-zero
  function automatic logic branch_taken(input logic branch,
                                        input logic br_type,
                                        input logic zero);
    logic cond;
    if (br_type == BR_BEQ)      cond = zero;
    else if (br_type == BR_BNE) cond = ~zero;
    else                        cond = 1'b0;
    return branch & cond;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register with bubble insertion
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              bubble_i,
  input  logic              MemtoReg_i,
  input  logic              RegWrite_i,
  input  logic [DATA_W-1:0] ALU_result_i,
  input  logic [DATA_W-1:0] read_data_i,
  input  logic [REG_AW-1:0] Reg_addr_i,
  output logic              MemtoReg_o,
  output logic              RegWrite_o,
  output logic [DATA_W-1:0] ALU_result_o,
  output logic [DATA_W-1:0] read_data_o,
  output logic [REG_AW-1:0] Reg_addr_o
);

  // A bubble clears every field so WB sees a harmless no-op
  always_ff @(posedge clk_i) begin
    if (!rst_i || bubble_i) begin
      MemtoReg_o   <= 1'b0;
      RegWrite_o   <= 1'b0;
      ALU_result_o <= '0;
      read_data_o  <= '0;
      Reg_addr_o   <= '0;
    end else begin
      MemtoReg_o   <= MemtoReg_i;
      RegWrite_o   <= RegWrite_i;
      ALU_result_o <= ALU_result_i;
      read_data_o  <= read_data_i;
      Reg_addr_o   <= Reg_addr_i;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage: branch resolution, data-memory handshake, MEM/WB register
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemtoReg_i,
  input  logic              RegWrite_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              Branch_i,
  input  logic              BranchType_i,
  input  logic              Jump_i,
  input  logic              zero_i,
  input  logic [DATA_W-1:0] pc_jump_i,
  input  logic [DATA_W-1:0] pc_branch_i,
  input  logic [DATA_W-1:0] ALU_result_i,
  input  logic [DATA_W-1:0] write_data_i,
  input  logic [REG_AW-1:0] Reg_addr_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              stall_o,
  output logic              pc_redirect_o,
  output logic [DATA_W-1:0] pc_target_o,
  output logic              flush_o,
  output logic              MemtoReg_o,
  output logic              RegWrite_o,
  output logic [DATA_W-1:0] ALU_result_o,
  output logic [DATA_W-1:0] read_data_o,
  output logic [REG_AW-1:0] Reg_addr_o,
  output logic              err_o
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;
  logic             access;
  logic             timeout_hit;
  logic             stall;
  logic             req;
  logic             redirect;
  logic             rd_ok;
  logic [DATA_W-1:0] wb_rdata;

  assign access      = MemRead_i | MemWrite_i;
  assign timeout_hit = (state_q == ST_WAIT) && !dmem_ack_i &&
                       (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    req     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req = access;
        if (access && !dmem_ack_i) begin
          stall   = 1'b1;
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        req = 1'b1;
        if (dmem_ack_i || timeout_hit) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  // Gating with reset lets an abandoned access drop its request immediately
  assign dmem_req_o   = rst_i & req;
  assign stall_o      = rst_i & stall;
  assign dmem_we_o    = MemWrite_i;
  assign dmem_addr_o  = ALU_result_i;
  assign dmem_wdata_o = write_data_i;
  assign err_o        = err_q;

  assign redirect      = rst_i & ~stall &
                         (Jump_i | branch_taken(Branch_i, BranchType_i, zero_i));
  assign pc_redirect_o = redirect;
  assign flush_o       = redirect;
  assign pc_target_o   = !redirect ? '0 : (Jump_i ? pc_jump_i : pc_branch_i);

  // Timeout completes with ack low, so it naturally yields zero read data
  assign rd_ok    = MemRead_i & ~MemWrite_i & dmem_ack_i;
  assign wb_rdata = rd_ok ? dmem_rdata_i : '0;

  mem_wb_reg u_mem_wb_reg (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bubble_i     (stall),
    .MemtoReg_i   (MemtoReg_i),
    .RegWrite_i   (RegWrite_i),
    .ALU_result_i (ALU_result_i),
    .read_data_i  (wb_rdata),
    .Reg_addr_i   (Reg_addr_i),
    .MemtoReg_o   (MemtoReg_o),
    .RegWrite_o   (RegWrite_o),
    .ALU_result_o (ALU_result_o),
    .read_data_o  (read_data_o),
    .Reg_addr_o   (Reg_addr_o)
  );

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;

  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemtoReg_i, RegWrite_i, MemRead_i, MemWrite_i;
  logic        Branch_i, BranchType_i, Jump_i, zero_i;
  logic [31:0] pc_jump_i, pc_branch_i, ALU_result_i, write_data_i;
  logic [4:0]  Reg_addr_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o, pc_redirect_o, flush_o;
  logic [31:0] pc_target_o;
  logic        MemtoReg_o, RegWrite_o;
  logic [31:0] ALU_result_o, read_data_o;
  logic [4:0]  Reg_addr_o;
  logic        err_o;
  logic [70:0] wb_act;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  assign wb_act = {RegWrite_o, MemtoReg_o, Reg_addr_o, ALU_result_o, read_data_o};

  mem_stage #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .MemtoReg_i    (MemtoReg_i),
    .RegWrite_i    (RegWrite_i),
    .MemRead_i     (MemRead_i),
    .MemWrite_i    (MemWrite_i),
    .Branch_i      (Branch_i),
    .BranchType_i  (BranchType_i),
    .Jump_i        (Jump_i),
    .zero_i        (zero_i),
    .pc_jump_i     (pc_jump_i),
    .pc_branch_i   (pc_branch_i),
    .ALU_result_i  (ALU_result_i),
    .write_data_i  (write_data_i),
    .Reg_addr_i    (Reg_addr_i),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_ack_i    (dmem_ack_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .stall_o       (stall_o),
    .pc_redirect_o (pc_redirect_o),
    .pc_target_o   (pc_target_o),
    .flush_o       (flush_o),
    .MemtoReg_o    (MemtoReg_o),
    .RegWrite_o    (RegWrite_o),
    .ALU_result_o  (ALU_result_o),
    .read_data_o   (read_data_o),
    .Reg_addr_o    (Reg_addr_o),
    .err_o         (err_o)
  );

  task automatic clear_inputs();
    MemtoReg_i = 0; RegWrite_i = 0; MemRead_i = 0; MemWrite_i = 0;
    Branch_i = 0; BranchType_i = 0; Jump_i = 0; zero_i = 0;
    pc_jump_i = 0; pc_branch_i = 0; ALU_result_i = 0; write_data_i = 0;
    Reg_addr_i = 0; dmem_ack_i = 0; dmem_rdata_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 0;
    MemRead_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checks++;
      if (dmem_req_o !== 1'b0) begin
        errors++; $display("FAIL reset_req cycle %0d: got %b want 0", i, dmem_req_o);
      end
      checks++;
      if ({stall_o, pc_redirect_o, flush_o, pc_target_o, err_o} !== 36'h0) begin
        errors++; $display("FAIL reset_ctrl cycle %0d: stall=%b redir=%b flush=%b tgt=%h err=%b want all 0",
                           i, stall_o, pc_redirect_o, flush_o, pc_target_o, err_o);
      end
      checks++;
      if (wb_act !== 71'h0) begin
        errors++; $display("FAIL reset_wb cycle %0d: got %h want 0", i, wb_act);
      end
    end
    rst_i = 1;
    MemRead_i = 0;
  endtask

  task automatic test_zero_wait_load();
    tick();
    clear_inputs();
    MemRead_i = 1; RegWrite_i = 1; MemtoReg_i = 1;
    ALU_result_i = 32'h40; Reg_addr_i = 5'd7;
    dmem_ack_i = 1; dmem_rdata_i = 32'hDEADBEEF;
    #2;
    checks++;
    if ({stall_o, dmem_req_o, dmem_we_o, dmem_addr_o} !== {1'b0, 1'b1, 1'b0, 32'h40}) begin
      errors++; $display("FAIL zw_load_comb: stall=%b req=%b we=%b addr=%h want 0 1 0 00000040",
                         stall_o, dmem_req_o, dmem_we_o, dmem_addr_o);
    end
    tick();
    clear_inputs();
    checks++;
    if (wb_act !== {1'b1, 1'b1, 5'd7, 32'h40, 32'hDEADBEEF}) begin
      errors++; $display("FAIL zw_load_wb: got %h want %h", wb_act,
                         {1'b1, 1'b1, 5'd7, 32'h40, 32'hDEADBEEF});
    end
  endtask

  task automatic test_wait_store();
    tick();
    clear_inputs();
    MemWrite_i = 1; RegWrite_i = 1; write_data_i = 32'h1234;
    ALU_result_i = 32'h80; Reg_addr_i = 5'd3;
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) begin
        tick();
        checks++;
        if (RegWrite_o !== 1'b0) begin
          errors++; $display("FAIL store_bubble cycle %0d: RegWrite_o=%b want 0", c, RegWrite_o);
        end
      end
      dmem_ack_i = (c == 3);
      #2;
      checks++;
      if (stall_o !== (c < 3)) begin
        errors++; $display("FAIL store_stall cycle %0d: got %b want %b", c, stall_o, (c < 3));
      end
      checks++;
      if ({dmem_req_o, dmem_we_o, dmem_wdata_o} !== {1'b1, 1'b1, 32'h1234}) begin
        errors++; $display("FAIL store_bus cycle %0d: req=%b we=%b wdata=%h want 1 1 00001234",
                           c, dmem_req_o, dmem_we_o, dmem_wdata_o);
      end
    end
    tick();
    clear_inputs();
    checks++;
    if (wb_act !== {1'b1, 1'b0, 5'd3, 32'h80, 32'h0}) begin
      errors++; $display("FAIL store_wb: got %h want %h", wb_act, {1'b1, 1'b0, 5'd3, 32'h80, 32'h0});
    end
  endtask

  task automatic test_timeout();
    int stall_cnt;
    stall_cnt = 0;
    tick();
    clear_inputs();
    MemRead_i = 1; RegWrite_i = 1; MemtoReg_i = 1;
    ALU_result_i = 32'h44; Reg_addr_i = 5'd9; dmem_rdata_i = 32'hBAD0BAD0;
    for (int c = 0; c <= TO; c++) begin
      if (c > 0) tick();
      #2;
      if (stall_o === 1'b1) stall_cnt++;
      checks++;
      if (stall_o !== (c < TO)) begin
        errors++; $display("FAIL timeout_stall cycle %0d: got %b want %b", c, stall_o, (c < TO));
      end
    end
    checks++;
    if (stall_cnt != TO) begin
      errors++; $display("FAIL timeout_stall_len: got %0d want %0d", stall_cnt, TO);
    end
    tick();
    clear_inputs();
    dmem_ack_i = 1;
    dmem_rdata_i = 32'hFFFFFFFF;
    checks++;
    if (wb_act !== {1'b1, 1'b1, 5'd9, 32'h44, 32'h0}) begin
      errors++; $display("FAIL timeout_wb: got %h want %h", wb_act, {1'b1, 1'b1, 5'd9, 32'h44, 32'h0});
    end
    checks++;
    if (err_o !== 1'b1) begin
      errors++; $display("FAIL timeout_err: got %b want 1", err_o);
    end
    #2;
    checks++;
    if ({dmem_req_o, stall_o} !== 2'b00) begin
      errors++; $display("FAIL late_ack_comb: req=%b stall=%b want 0 0", dmem_req_o, stall_o);
    end
    tick();
    clear_inputs();
    checks++;
    if ({read_data_o, err_o} !== {32'h0, 1'b1}) begin
      errors++; $display("FAIL late_ack_wb: rdata=%h err=%b want 00000000 1", read_data_o, err_o);
    end
    rst_i = 0;
    tick();
    rst_i = 1;
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL err_clear: got %b want 0", err_o);
    end
  endtask

  task automatic test_branch();
    tick();
    clear_inputs();
    Branch_i = 1; BranchType_i = 1; zero_i = 0; pc_branch_i = 32'h100; pc_jump_i = 32'h300;
    #2;
    checks++;
    if ({pc_redirect_o, flush_o, pc_target_o} !== {1'b1, 1'b1, 32'h100}) begin
      errors++; $display("FAIL bne_taken: redir=%b flush=%b tgt=%h want 1 1 00000100",
                         pc_redirect_o, flush_o, pc_target_o);
    end
    zero_i = 1;
    #2;
    checks++;
    if ({pc_redirect_o, flush_o, pc_target_o} !== 34'h0) begin
      errors++; $display("FAIL bne_not_taken: redir=%b flush=%b tgt=%h want 0 0 0",
                         pc_redirect_o, flush_o, pc_target_o);
    end
    BranchType_i = 0;
    #2;
    checks++;
    if ({pc_redirect_o, flush_o, pc_target_o} !== {1'b1, 1'b1, 32'h100}) begin
      errors++; $display("FAIL beq_taken: redir=%b flush=%b tgt=%h want 1 1 00000100",
                         pc_redirect_o, flush_o, pc_target_o);
    end
  endtask

  task automatic test_jump_priority();
    tick();
    clear_inputs();
    Jump_i = 1; Branch_i = 1; BranchType_i = 0; zero_i = 1;
    pc_jump_i = 32'h200; pc_branch_i = 32'h100;
    #2;
    checks++;
    if ({pc_redirect_o, flush_o, pc_target_o} !== {1'b1, 1'b1, 32'h200}) begin
      errors++; $display("FAIL jump_priority: redir=%b flush=%b tgt=%h want 1 1 00000200",
                         pc_redirect_o, flush_o, pc_target_o);
    end
  endtask

  task automatic test_mid_wait_reset();
    tick();
    clear_inputs();
    MemRead_i = 1;
    tick();
    tick();
    #2;
    checks++;
    if ({dmem_req_o, stall_o} !== 2'b11) begin
      errors++; $display("FAIL midwait_pre: req=%b stall=%b want 1 1", dmem_req_o, stall_o);
    end
    rst_i = 0;
    #1;
    checks++;
    if (dmem_req_o !== 1'b0) begin
      errors++; $display("FAIL midwait_req_drop: got %b want 0", dmem_req_o);
    end
    tick();
    rst_i = 1;
    MemRead_i = 0;
    #2;
    checks++;
    if ({dmem_req_o, stall_o} !== 2'b00) begin
      errors++; $display("FAIL midwait_idle: req=%b stall=%b want 0 0", dmem_req_o, stall_o);
    end
  endtask

  task automatic test_random();
    logic [70:0] exp_wb;
    logic        have_exp;
    logic        exp_err;
    rst_i = 0;
    tick();
    clear_inputs();
    rst_i = 1;
    have_exp = 0;
    exp_err  = 0;
    for (int n = 0; n < 40; n++) begin
      logic        rd, wr, rw, m2r, br, bt, jp, zr, access, timed, taken;
      logic [31:0] pcj, pcb, alu, wd, memval;
      logic [4:0]  ra;
      int          lat, nstall, r;
      rd  = ($urandom_range(0, 2) == 0);
      wr  = ($urandom_range(0, 3) == 0);
      rw  = ($urandom_range(0, 1) == 1);
      m2r = ($urandom_range(0, 1) == 1);
      br  = ($urandom_range(0, 2) == 0);
      bt  = ($urandom_range(0, 1) == 1);
      jp  = ($urandom_range(0, 5) == 0);
      zr  = ($urandom_range(0, 1) == 1);
      pcj = $urandom; pcb = $urandom; alu = $urandom; wd = $urandom; memval = $urandom;
      ra  = 5'($urandom_range(0, 31));
      access = rd | wr;
      r = int'($urandom_range(0, 9));
      lat    = !access ? 0 : (r < 6 ? r : (r < 8 ? TO : 99));
      nstall = (lat < TO) ? lat : TO;
      timed  = access && (lat > TO);
      taken  = br && (bt ? !zr : zr);
      for (int c = 0; c <= nstall; c++) begin
        logic exp_stall, exp_red;
        tick();
        if (have_exp) begin
          checks++;
          if (wb_act !== exp_wb) begin
            errors++; $display("FAIL rand_wb instr %0d cycle %0d: got %h want %h", n, c, wb_act, exp_wb);
          end
          checks++;
          if (err_o !== exp_err) begin
            errors++; $display("FAIL rand_err instr %0d cycle %0d: got %b want %b", n, c, err_o, exp_err);
          end
        end
        MemRead_i = rd; MemWrite_i = wr; RegWrite_i = rw; MemtoReg_i = m2r;
        Branch_i = br; BranchType_i = bt; Jump_i = jp; zero_i = zr;
        pc_jump_i = pcj; pc_branch_i = pcb; ALU_result_i = alu; write_data_i = wd;
        Reg_addr_i = ra;
        if (access) begin
          dmem_ack_i   = (c == lat);
          dmem_rdata_i = (c == lat) ? memval : $urandom;
        end else begin
          dmem_ack_i   = ($urandom_range(0, 1) == 1);
          dmem_rdata_i = $urandom;
        end
        #2;
        exp_stall = (c < nstall);
        exp_red   = !exp_stall && (jp || taken);
        checks++;
        if ({stall_o, dmem_req_o, dmem_we_o} !== {exp_stall, access, wr}) begin
          errors++; $display("FAIL rand_mem instr %0d cycle %0d: stall=%b req=%b we=%b want %b %b %b",
                             n, c, stall_o, dmem_req_o, dmem_we_o, exp_stall, access, wr);
        end
        checks++;
        if ({pc_redirect_o, flush_o, pc_target_o} !==
            {exp_red, exp_red, (exp_red ? (jp ? pcj : pcb) : 32'h0)}) begin
          errors++; $display("FAIL rand_redirect instr %0d cycle %0d: redir=%b flush=%b tgt=%h want %b %h",
                             n, c, pc_redirect_o, flush_o, pc_target_o, exp_red,
                             (exp_red ? (jp ? pcj : pcb) : 32'h0));
        end
        if (exp_stall) exp_wb = '0;
        else exp_wb = {rw, m2r, ra, alu, ((rd && !wr && !timed) ? memval : 32'h0)};
        if (!exp_stall && timed) exp_err = 1'b1;
        have_exp = 1;
      end
    end
    tick();
    clear_inputs();
    checks++;
    if (wb_act !== exp_wb) begin
      errors++; $display("FAIL rand_wb_last: got %h want %h", wb_act, exp_wb);
    end
  endtask

  initial begin
    clear_inputs();
    rst_i = 0;
    test_reset();
    test_zero_wait_load();
    test_wait_store();
    test_timeout();
    test_branch();
    test_jump_priority();
    test_mid_wait_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage; consumes the EX/MEM register outputs directly.
- Resolves branch/jump and drives the PC redirect and flush.
- Performs the data-memory access over a req/ack handshake, asserting stall while the access is outstanding.
- Registers results into MEM/WB outputs consumed by the WB stage.

Parameters:
- TIMEOUT, 16, max cycles an access may wait for dmem_ack_i before forced completion.
- CNT_W, 5, width of timeout counter (must hold TIMEOUT).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-low
- MemtoReg_i, RegWrite_i, MemRead_i, MemWrite_i, Branch_i, BranchType_i, Jump_i, zero_i  in  1 each  EX/MEM controls/flags
- pc_jump_i, pc_branch_i, ALU_result_i, write_data_i  in  32 each  EX/MEM data
- Reg_addr_i  in  5  destination register
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1 = write
- dmem_addr_o, dmem_wdata_o  out  32  = ALU_result_i, write_data_i
- dmem_ack_i  in  1  access complete this cycle
- dmem_rdata_i  in  32  read data, valid with ack
- stall_o  out  1  freeze IF..EX/MEM this cycle
- pc_redirect_o  out  1  load pc_target_o into PC
- pc_target_o  out  32  redirect target
- flush_o  out  1  squash IF/ID, ID/EX, EX/MEM
- MemtoReg_o, RegWrite_o  out  1  MEM/WB controls
- ALU_result_o, read_data_o  out  32  MEM/WB data
- Reg_addr_o  out  5  MEM/WB destination
- err_o  out  1  sticky timeout flag

Behaviour:
- Reset (rst_i=0 at posedge): FSM→IDLE, counter=0, all registered outputs 0, err_o=0; in-flight access abandoned, dmem_req_o drops the same cycle reset is sampled low.
- access = MemRead_i | MemWrite_i; both set → treated as write.
- dmem_we_o = MemWrite_i; addr/wdata driven combinationally from inputs; inputs are held stable by upstream while stall_o=1.
- FSM states:
  - IDLE:
    - access & dmem_ack_i → zero-wait completion, stall_o=0.
    - access & !ack → stall_o=1, go WAIT, counter=1.
    - No access → stall_o=0.
  - WAIT: dmem_req_o=1, stall_o=1 until completion.
    - ack → stall_o=0 that cycle, go IDLE.
    - counter==TIMEOUT without ack → forced completion: stall_o=0, read data=0, err_o←1 (sticky until reset), go IDLE.
    - Otherwise counter++.
- dmem_req_o = access in IDLE, 1 in WAIT.
- MEM/WB register, every posedge:
  - Stall cycle → load bubble (RegWrite_o=0, MemtoReg_o=0, others 0).
  - Otherwise load inputs; read_data_o ← dmem_rdata_i on read ack, 0 on timeout or non-read.
- Latency: result appears at MEM/WB outputs 1 cycle after completion.
- Branch resolution (combinational, only on non-stall cycles):
  - taken = Branch_i & (zero_i ^ BranchType_i); BranchType 0 = beq, 1 = bne.
  - Jump_i has priority: target = pc_jump_i; else target = pc_branch_i.
  - pc_redirect_o = flush_o = Jump_i | taken; pc_target_o = 0 when no redirect.
- Redirect is a one-cycle pulse per instruction; never asserted with stall_o.
- Branch/jump with access bits set → resolve normally, access still performed.
- Ack in IDLE without access → ignored. Ack late after timeout → ignored.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=0, WAIT=1).
  - BR_BEQ=0, BR_BNE=1.
  - DATA_W=32, REG_AW=5.
- Sub-module mem_wb_reg: MEM/WB register with bubble-insert input; FSM, counter and branch logic stay in mem_stage.

Test Plan:
- Reset: hold rst_i=0 3 cycles with MemRead_i=1 → dmem_req_o=0, all outputs 0, err_o=0.
- Zero-wait load: MemRead_i=1, ALU_result_i=0x40, ack same cycle with rdata=0xDEADBEEF, Reg_addr_i=7 → stall_o=0; next cycle read_data_o=0xDEADBEEF, Reg_addr_o=7, RegWrite_o as input.
- Wait-state store: MemWrite_i=1, write_data_i=0x1234, ack after 3 cycles → stall_o=1 for 3 cycles, req held, dmem_we_o=1, RegWrite_o=0 bubbles during stall.
- Timeout: MemRead_i=1, never ack, TIMEOUT=16 → stall_o high 16 cycles then 0, read_data_o=0, err_o=1 until reset.
- Branch:
  - Branch_i=1, BranchType_i=1, zero_i=0, pc_branch_i=0x100 → pc_redirect_o=flush_o=1, pc_target_o=0x100.
  - Same with zero_i=1 → no redirect.
- Jump priority: Jump_i=1, Branch_i=1 taken, pc_jump_i=0x200 → pc_target_o=0x200; mid-WAIT reset → FSM IDLE, req drops.
